// File: rtl/ram_pkg.sv
// Shared definitions for the byte-enable two-port RAM with post-reset zero fill.
package ram_pkg;

    // Legal read latencies
    localparam int unsigned RD_LAT_1 = 1;
    localparam int unsigned RD_LAT_2 = 2;

    // Controller states
    typedef enum logic [1:0] {
        IDLE,
        INIT,
        READY
    } ram_state_e;

    // Elaboration-time parameter sanity check
    function automatic bit ram_params_ok(input int unsigned data_w, input int unsigned rd_lat);
        return (data_w != 0) && ((data_w % 8) == 0) &&
               ((rd_lat == RD_LAT_1) || (rd_lat == RD_LAT_2));
    endfunction

endpackage

// File: rtl/ram_core_be.sv
// Bare 1W/1R storage array: per-byte write, registered read.
module ram_core_be #(
    parameter int unsigned DATA_W = 512,
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned ADDR_W = 12,
    localparam int unsigned BE_W  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [BE_W-1:0]   w_be,
    input  logic [DATA_W-1:0] w_data,
    input  logic              r_en,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [DATA_W-1:0] r_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-lane masked write; caller guarantees the address is in range
    always_ff @(posedge clk) begin
        if (w_en) begin
            for (int unsigned i = 0; i < BE_W; i++) begin
                if (w_be[i]) begin
                    mem[w_addr][8*i +: 8] <= w_data[8*i +: 8];
                end
            end
        end
    end

    // Registered read; holds its value when no read is issued (returns pre-write data)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else if (r_en) begin
            r_data <= mem[r_addr];
        end
    end

endmodule

// File: rtl/two_port_ram_be_init.sv
// Single-clock 1W/1R RAM with byte enables, zero-fill after reset, optional
// write-to-read forwarding and a 1- or 2-cycle read pipeline.
module two_port_ram_be_init
    import ram_pkg::*;
#(
    parameter int unsigned DATA_W        = 512,
    parameter int unsigned DEPTH         = 4096,
    parameter int unsigned ADDR_W        = $clog2(DEPTH),
    parameter int unsigned RD_LAT        = 1,
    parameter bit          BYPASS        = 1'b1,
    parameter bit          INIT_ON_RESET = 1'b1,
    localparam int unsigned BE_W         = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [BE_W-1:0]   w_be,
    input  logic [DATA_W-1:0] w_data,
    input  logic              r_en,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [DATA_W-1:0] r_data,
    output logic              r_valid,
    output logic              init_busy,
    output logic              init_done
);

    if (!ram_params_ok(DATA_W, RD_LAT)) begin : gen_param_err
        $error("two_port_ram_be_init: DATA_W must be a multiple of 8, RD_LAT 1 or 2");
    end

    // One extra bit so the range compare also works when DEPTH is a power of two
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    ram_state_e        state_q;
    logic [ADDR_W-1:0] fill_cnt_q;
    logic              init_busy_q;
    logic              init_done_q;

    // Controller FSM with fill counter and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            fill_cnt_q  <= '0;
            init_busy_q <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    fill_cnt_q <= '0;
                    if (INIT_ON_RESET) begin
                        state_q     <= INIT;
                        init_busy_q <= 1'b1;
                    end else begin
                        state_q     <= READY;
                        init_done_q <= 1'b1;
                    end
                end
                INIT: begin
                    if (fill_cnt_q == LAST_ADDR) begin
                        state_q     <= READY;
                        init_busy_q <= 1'b0;
                        init_done_q <= 1'b1;
                    end else begin
                        fill_cnt_q <= fill_cnt_q + 1'b1;
                    end
                end
                READY: begin
                    state_q <= READY;
                end
                default: begin
                    state_q     <= IDLE;
                    init_busy_q <= 1'b0;
                    init_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign init_busy = init_busy_q;
    assign init_done = init_done_q;

    logic w_in_range;
    logic r_in_range;
    logic user_wr;
    logic rd_acc;
    logic in_init;

    assign in_init    = (state_q == INIT);
    assign w_in_range = ({1'b0, w_addr} < DEPTH_X);
    assign r_in_range = ({1'b0, r_addr} < DEPTH_X);
    assign user_wr    = (state_q == READY) && w_en && w_in_range;
    assign rd_acc     = (state_q == READY) && r_en;

    logic              core_we;
    logic [ADDR_W-1:0] core_waddr;
    logic [BE_W-1:0]   core_be;
    logic [DATA_W-1:0] core_wdata;
    logic              core_re;
    logic [DATA_W-1:0] core_rdata;

    // Write-port mux: the fill sequencer owns the port during INIT
    always_comb begin
        core_we    = in_init || user_wr;
        core_waddr = in_init ? fill_cnt_q : w_addr;
        core_be    = in_init ? {BE_W{1'b1}} : w_be;
        core_wdata = in_init ? '0 : w_data;
        core_re    = rd_acc && r_in_range;
    end

    ram_core_be #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .w_en   (core_we),
        .w_addr (core_waddr),
        .w_be   (core_be),
        .w_data (core_wdata),
        .r_en   (core_re),
        .r_addr (r_addr),
        .r_data (core_rdata)
    );

    logic              rd_v1_q;
    logic              oor_q;
    logic              coll_q;
    logic [BE_W-1:0]   byp_be_q;
    logic [DATA_W-1:0] byp_data_q;

    // Capture per-read side info alongside the array read; held between reads
    // so the merged result stays stable when no new result is due
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_v1_q    <= 1'b0;
            oor_q      <= 1'b0;
            coll_q     <= 1'b0;
            byp_be_q   <= '0;
            byp_data_q <= '0;
        end else begin
            rd_v1_q <= rd_acc;
            if (rd_acc) begin
                oor_q      <= !r_in_range;
                coll_q     <= BYPASS && user_wr && (w_addr == r_addr);
                byp_be_q   <= w_be;
                byp_data_q <= w_data;
            end
        end
    end

    logic [DATA_W-1:0] rd1_data;

    // Forward written lanes on collision; out-of-range reads return zero
    always_comb begin
        rd1_data = core_rdata;
        for (int unsigned i = 0; i < BE_W; i++) begin
            if (coll_q && byp_be_q[i]) begin
                rd1_data[8*i +: 8] = byp_data_q[8*i +: 8];
            end
        end
        if (oor_q) begin
            rd1_data = '0;
        end
    end

    if (RD_LAT == RD_LAT_2) begin : gen_lat2
        logic [DATA_W-1:0] r_data_q;
        logic              r_valid_q;

        // Extra output stage; data only advances with a valid result
        always_ff @(posedge clk) begin
            if (rst) begin
                r_data_q  <= '0;
                r_valid_q <= 1'b0;
            end else begin
                r_valid_q <= rd_v1_q;
                if (rd_v1_q) begin
                    r_data_q <= rd1_data;
                end
            end
        end

        assign r_data  = r_data_q;
        assign r_valid = r_valid_q;
    end else begin : gen_lat1
        assign r_data  = rd1_data;
        assign r_valid = rd_v1_q;
    end

endmodule

// File: tb/tb_two_port_ram_be_init.sv
// Directed bench: three instances share stimulus.
//   u_a: DEPTH 16, RD_LAT 1, BYPASS 1
//   u_b: DEPTH 16, RD_LAT 2, BYPASS 0
//   u_c: DEPTH 12, RD_LAT 1, BYPASS 1
module tb_two_port_ram_be_init;

    logic        clk;
    logic        rst;
    logic        w_en;
    logic [3:0]  w_addr;
    logic [7:0]  w_be;
    logic [63:0] w_data;
    logic        r_en;
    logic [3:0]  r_addr;

    logic [63:0] a_data, b_data, c_data;
    logic        a_valid, b_valid, c_valid;
    logic        a_busy, b_busy, c_busy;
    logic        a_done, b_done, c_done;

    int n_tests = 0;
    int n_fail  = 0;

    two_port_ram_be_init #(
        .DATA_W(64), .DEPTH(16), .RD_LAT(1), .BYPASS(1'b1), .INIT_ON_RESET(1'b1)
    ) u_a (
        .clk(clk), .rst(rst), .w_en(w_en), .w_addr(w_addr), .w_be(w_be), .w_data(w_data),
        .r_en(r_en), .r_addr(r_addr), .r_data(a_data), .r_valid(a_valid),
        .init_busy(a_busy), .init_done(a_done)
    );

    two_port_ram_be_init #(
        .DATA_W(64), .DEPTH(16), .RD_LAT(2), .BYPASS(1'b0), .INIT_ON_RESET(1'b1)
    ) u_b (
        .clk(clk), .rst(rst), .w_en(w_en), .w_addr(w_addr), .w_be(w_be), .w_data(w_data),
        .r_en(r_en), .r_addr(r_addr), .r_data(b_data), .r_valid(b_valid),
        .init_busy(b_busy), .init_done(b_done)
    );

    two_port_ram_be_init #(
        .DATA_W(64), .DEPTH(12), .RD_LAT(1), .BYPASS(1'b1), .INIT_ON_RESET(1'b1)
    ) u_c (
        .clk(clk), .rst(rst), .w_en(w_en), .w_addr(w_addr), .w_be(w_be), .w_data(w_data),
        .r_en(r_en), .r_addr(r_addr), .r_data(c_data), .r_valid(c_valid),
        .init_busy(c_busy), .init_done(c_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Write only, one cycle
    task automatic wr(input logic [3:0] wa, input logic [7:0] be, input logic [63:0] wd);
        @(negedge clk);
        w_en = 1'b1; w_addr = wa; w_be = be; w_data = wd;
        @(posedge clk);
        #1 w_en = 1'b0;
    endtask

    // Read (optionally with a simultaneous write) and check all three instances
    task automatic xact(input string tag, input logic we, input logic [3:0] wa,
                        input logic [7:0] be, input logic [63:0] wd, input logic [3:0] ra,
                        input logic [63:0] ea, input logic [63:0] eb, input logic [63:0] ec);
        @(negedge clk);
        w_en = we; w_addr = wa; w_be = be; w_data = wd;
        r_en = 1'b1; r_addr = ra;
        @(posedge clk);
        #1 w_en = 1'b0; r_en = 1'b0;
        @(negedge clk);
        check({tag, "_a_valid"}, 64'(a_valid), 64'd1);
        check({tag, "_a_data"}, a_data, ea);
        check({tag, "_c_valid"}, 64'(c_valid), 64'd1);
        check({tag, "_c_data"}, c_data, ec);
        check({tag, "_b_early"}, 64'(b_valid), 64'd0);
        @(negedge clk);
        check({tag, "_b_valid"}, 64'(b_valid), 64'd1);
        check({tag, "_b_data"}, b_data, eb);
        check({tag, "_a_pulse"}, 64'(a_valid), 64'd0);
        check({tag, "_a_hold"}, a_data, ea);
    endtask

    // Release reset, watch the fill, and poke a write/read into the INIT window
    task automatic run_fill(input string tag);
        int na, nb, nc, nv;
        na = 0; nb = 0; nc = 0; nv = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            na += int'(a_busy);
            nb += int'(b_busy);
            nc += int'(c_busy);
            nv += int'(a_valid) + int'(b_valid) + int'(c_valid);
            if (i == 3) begin
                w_en = 1'b1; w_addr = 4'd2; w_be = 8'hFF; w_data = 64'hFFFF_FFFF_FFFF_FFFF;
                r_en = 1'b1; r_addr = 4'd2;
            end else begin
                w_en = 1'b0; r_en = 1'b0;
            end
        end
        check({tag, "_a_busy_cycles"}, 64'(na), 64'd16);
        check({tag, "_b_busy_cycles"}, 64'(nb), 64'd16);
        check({tag, "_c_busy_cycles"}, 64'(nc), 64'd12);
        check({tag, "_no_valid_in_init"}, 64'(nv), 64'd0);
        check({tag, "_a_done"}, 64'(a_done), 64'd1);
        check({tag, "_b_done"}, 64'(b_done), 64'd1);
        check({tag, "_c_done"}, 64'(c_done), 64'd1);
        check({tag, "_a_busy_end"}, 64'(a_busy), 64'd0);
    endtask

    task automatic read_all(input string tag);
        for (int k = 0; k < 16; k++) begin
            xact($sformatf("%s_%0d", tag, k), 1'b0, 4'd0, 8'h00, 64'd0, 4'(k),
                 64'd0, 64'd0, 64'd0);
        end
    endtask

    initial begin
        rst = 1'b1; w_en = 1'b0; w_addr = '0; w_be = '0; w_data = '0;
        r_en = 1'b0; r_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_a_data", a_data, 64'd0);
        check("rst_b_data", b_data, 64'd0);
        check("rst_a_valid", 64'(a_valid), 64'd0);
        check("rst_b_valid", 64'(b_valid), 64'd0);
        check("rst_a_busy", 64'(a_busy), 64'd0);
        check("rst_a_done", 64'(a_done), 64'd0);
        check("rst_c_done", 64'(c_done), 64'd0);

        run_fill("fill1");
        read_all("zero1");

        // Full-word write then read
        wr(4'd3, 8'hFF, 64'h1122_3344_5566_77FF);
        xact("full_wr", 1'b0, 4'd0, 8'h00, 64'd0, 4'd3,
             64'h1122_3344_5566_77FF, 64'h1122_3344_5566_77FF, 64'h1122_3344_5566_77FF);

        // Byte-lane partial overwrite
        wr(4'd4, 8'hFF, 64'hAAAA_AAAA_AAAA_AAAA);
        wr(4'd4, 8'h0F, 64'h5555_5555_5555_5555);
        xact("byte_en", 1'b0, 4'd0, 8'h00, 64'd0, 4'd4,
             64'hAAAA_AAAA_5555_5555, 64'hAAAA_AAAA_5555_5555, 64'hAAAA_AAAA_5555_5555);

        // Same-cycle collision: forwarding vs old data, then settled value
        xact("coll", 1'b1, 4'd5, 8'h03, 64'h0000_0000_0000_DEAD, 4'd5,
             64'h0000_0000_0000_DEAD, 64'd0, 64'h0000_0000_0000_DEAD);
        xact("coll_after", 1'b0, 4'd0, 8'h00, 64'd0, 4'd5,
             64'h0000_0000_0000_DEAD, 64'h0000_0000_0000_DEAD, 64'h0000_0000_0000_DEAD);

        // All-zero byte enables leave the word untouched
        wr(4'd3, 8'h00, 64'h0);
        xact("be_zero", 1'b0, 4'd0, 8'h00, 64'd0, 4'd3,
             64'h1122_3344_5566_77FF, 64'h1122_3344_5566_77FF, 64'h1122_3344_5566_77FF);

        // Address 13 is out of range only for the 12-deep instance
        wr(4'd13, 8'hFF, 64'h7777_7777_7777_7777);
        xact("oor13", 1'b0, 4'd0, 8'h00, 64'd0, 4'd13,
             64'h7777_7777_7777_7777, 64'h7777_7777_7777_7777, 64'd0);
        xact("oor_alias1", 1'b0, 4'd0, 8'h00, 64'd0, 4'd1, 64'd0, 64'd0, 64'd0);
        xact("oor_alias9", 1'b0, 4'd0, 8'h00, 64'd0, 4'd9, 64'd0, 64'd0, 64'd0);

        // Reset while a read is in flight
        @(negedge clk);
        r_en = 1'b1; r_addr = 4'd3;
        @(posedge clk);
        #1 r_en = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("inflight_a_data", a_data, 64'h1122_3344_5566_77FF);
        @(negedge clk);
        check("inflight_b_valid", 64'(b_valid), 64'd0);
        check("inflight_a_valid", 64'(a_valid), 64'd0);
        check("inflight_a_data_rst", a_data, 64'd0);
        check("inflight_b_data_rst", b_data, 64'd0);
        check("inflight_a_done_rst", 64'(a_done), 64'd0);

        // Reset mid-fill when the counter is at 7
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("midfill_busy", 64'(a_busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midfill_busy_rst", 64'(a_busy), 64'd0);

        run_fill("fill2");
        read_all("zero2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
